// File: rtl/seq_multiplier.sv
// Sequential radix-2 shift-add multiplier with optional two's-complement operands.
// It multiplies the operand magnitudes over WIDTH RUN cycles.
// It then applies the latched result sign in a single SIGN cycle.
// done pulses for one cycle when productHi/productLo take the new result.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signedOp,
    input  logic [WIDTH-1:0] multiplicandIn,
    input  logic [WIDTH-1:0] multiplierIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] productHi,
    output logic [WIDTH-1:0] productLo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t               state_reg;
    logic [WIDTH-1:0]     mcand_reg;
    logic [WIDTH-1:0]     mplr_reg;
    logic [2*WIDTH-1:0]   acc_reg;
    logic [CW-1:0]        count_reg;
    logic                 sign_reg;

    logic [WIDTH-1:0]     mcand_mag;
    logic [WIDTH-1:0]     mplr_mag;
    logic                 sign_next;
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   acc_final;

    // Operand magnitudes, one shift-add step, and the sign-corrected final product
    always_comb begin
        mcand_mag = multiplicandIn;
        mplr_mag  = multiplierIn;
        if (signedOp && multiplicandIn[WIDTH-1]) begin
            mcand_mag = -multiplicandIn;
        end
        if (signedOp && multiplierIn[WIDTH-1]) begin
            mplr_mag = -multiplierIn;
        end
        sign_next = signedOp & (multiplicandIn[WIDTH-1] ^ multiplierIn[WIDTH-1]);

        // The carry out of the upper-half add becomes the new MSB after the shift
        addend    = mplr_reg[0] ? mcand_reg : '0;
        sum       = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        acc_step  = {sum, acc_reg[WIDTH-1:1]};

        acc_final = sign_reg ? -acc_reg : acc_reg;
    end

    // Control FSM and datapath registers; reset wins over every other activity
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            mcand_reg <= '0;
            mplr_reg  <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
            sign_reg  <= 1'b0;
            done      <= 1'b0;
            productHi <= '0;
            productLo <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        mcand_reg <= mcand_mag;
                        mplr_reg  <= mplr_mag;
                        sign_reg  <= sign_next;
                        acc_reg   <= '0;
                        count_reg <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    acc_reg   <= acc_step;
                    mplr_reg  <= {1'b0, mplr_reg[WIDTH-1:1]};
                    count_reg <= count_reg + CW'(1);
                    if (count_reg == LAST_STEP) begin
                        state_reg <= SIGN;
                    end
                end
                SIGN: begin
                    productHi <= acc_final[2*WIDTH-1:WIDTH];
                    productLo <= acc_final[WIDTH-1:0];
                    done      <= 1'b1;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_reg == RUN) || (state_reg == SIGN);

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier: latency, sign handling, ignored starts,
// back-to-back operation and mid-operation reset.
module tb_seq_multiplier;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signedOp;
    logic [31:0] multiplicandIn;
    logic [31:0] multiplierIn;
    logic        busy;
    logic        done;
    logic [31:0] productHi;
    logic [31:0] productLo;

    int pass_cnt  = 0;
    int check_cnt = 0;

    logic [31:0] prev_hi;
    logic [31:0] prev_lo;

    seq_multiplier #(.WIDTH(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .signedOp       (signedOp),
        .multiplicandIn (multiplicandIn),
        .multiplierIn   (multiplierIn),
        .busy           (busy),
        .done           (done),
        .productHi      (productHi),
        .productLo      (productLo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive a start request in the current cycle (caller is at a negedge)
    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
        start          = 1'b1;
        signedOp       = s;
        multiplicandIn = a;
        multiplierIn   = b;
    endtask

    // Follow an issued operation through cycles 1..34 and check timing, hold and result
    task automatic watch(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                         input bit repulse);
        int   bad_k;
        int   hold_k;
        logic bb, bd;
        logic [31:0] hh, hl;
        bad_k  = -1;
        hold_k = -1;
        bb = 1'b0; bd = 1'b0; hh = '0; hl = '0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (((busy !== (k <= 33)) || (done !== (k == 34))) && bad_k < 0) begin
                bad_k = k; bb = busy; bd = done;
            end
            if (k <= 33 && (productHi !== prev_hi || productLo !== prev_lo) && hold_k < 0) begin
                hold_k = k; hh = productHi; hl = productLo;
            end
            if (k == 34) begin
                // leave start alone: the caller may issue the next operation here
            end else if (repulse && (k == 5 || k == 20)) begin
                issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            end else begin
                start = 1'b0;
            end
        end
        check_cnt++;
        if (bad_k < 0) pass_cnt++;
        else $display("FAIL %s timing: cycle %0d busy=%b done=%b, required busy=%b done=%b",
                      name, bad_k, bb, bd, (bad_k <= 33), (bad_k == 34));
        check_cnt++;
        if (hold_k < 0) pass_cnt++;
        else $display("FAIL %s hold: cycle %0d product=%h_%h, required %h_%h",
                      name, hold_k, hh, hl, prev_hi, prev_lo);
        check_cnt++;
        if (productHi === exp_hi) pass_cnt++;
        else $display("FAIL %s productHi: got %h, required %h", name, productHi, exp_hi);
        check_cnt++;
        if (productLo === exp_lo) pass_cnt++;
        else $display("FAIL %s productLo: got %h, required %h", name, productLo, exp_lo);
        $display("op %s: product=%h_%h expected=%h_%h", name, productHi, productLo, exp_hi, exp_lo);
        prev_hi = exp_hi;
        prev_lo = exp_lo;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; signedOp = 1'b0;
        multiplicandIn = '0; multiplierIn = '0;
        repeat (3) @(negedge clk);
        check_cnt++;
        if (busy === 1'b0) pass_cnt++;
        else $display("FAIL reset busy: got %b, required 0", busy);
        check_cnt++;
        if (done === 1'b0) pass_cnt++;
        else $display("FAIL reset done: got %b, required 0", done);
        check_cnt++;
        if (productHi === 32'h0) pass_cnt++;
        else $display("FAIL reset productHi: got %h, required 00000000", productHi);
        check_cnt++;
        if (productLo === 32'h0) pass_cnt++;
        else $display("FAIL reset productLo: got %h, required 00000000", productLo);
        $display("reset: busy=%b done=%b product=%h_%h", busy, done, productHi, productLo);
        prev_hi = 32'h0;
        prev_lo = 32'h0;
        reset = 1'b0;
    endtask

    // Start in the very cycle reset deasserts
    task automatic test_unsigned_max();
        issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watch("unsigned_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    endtask

    task automatic test_sign_modes();
        issue(1'b1, 32'hFFFF_FFFD, 32'h0000_0007);
        watch("signed_m3x7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        issue(1'b0, 32'hFFFF_FFFD, 32'h0000_0007);
        watch("unsigned_m3x7", 32'h0000_0006, 32'hFFFF_FFEB, 1'b0);
    endtask

    task automatic test_min_int();
        issue(1'b1, 32'h8000_0000, 32'h8000_0000);
        watch("signed_min_sq", 32'h4000_0000, 32'h0000_0000, 1'b0);
        issue(1'b1, 32'h8000_0000, 32'h0000_0001);
        watch("signed_min_x1", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    endtask

    // Starts in cycles 5 and 20 carry different operands and must be ignored
    task automatic test_zero_ignore_start();
        issue(1'b1, 32'h0000_0000, 32'h1234_5678);
        watch("zero_ignore", 32'h0000_0000, 32'h0000_0000, 1'b1);
    endtask

    // Start issued in the previous done cycle
    task automatic test_back_to_back();
        issue(1'b0, 32'h0000_0002, 32'h0000_0003);
        watch("b2b_2x3", 32'h0000_0000, 32'h0000_0006, 1'b0);
    endtask

    task automatic test_reset_abort();
        int done_seen;
        issue(1'b0, 32'h0000_0005, 32'h0000_0005);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) reset = 1'b1;
        end
        @(negedge clk);
        check_cnt++;
        if (busy === 1'b0) pass_cnt++;
        else $display("FAIL abort busy: got %b, required 0", busy);
        check_cnt++;
        if (done === 1'b0) pass_cnt++;
        else $display("FAIL abort done: got %b, required 0", done);
        check_cnt++;
        if (productHi === 32'h0 && productLo === 32'h0) pass_cnt++;
        else $display("FAIL abort product: got %h_%h, required 0000000000000000", productHi, productLo);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 12; k <= 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0) done_seen++;
        end
        check_cnt++;
        if (done_seen == 0) pass_cnt++;
        else $display("FAIL abort no_done: got %0d done cycles, required 0", done_seen);
        $display("abort: busy=%b done=%b product=%h_%h stray_done=%0d", busy, done, productHi, productLo, done_seen);
        prev_hi = 32'h0;
        prev_lo = 32'h0;
    endtask

    task automatic test_signed_neg_one();
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        watch("signed_m1xm1", 32'h0000_0000, 32'h0000_0001, 1'b0);
        start = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_sign_modes();
        test_min_int();
        test_zero_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_signed_neg_one();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
